logic16_arbiter: RTL and testbench
==================================

// Module: logic16_arbiter
// PURPOSE
//  Shares one 16-bit bitwise logic unit (OR/AND/XOR/NOT) between N requesters.
//  Round-robin grant, valid/ready on both sides, registered result tagged with
//  requester id. Sits between CPU-side clients and the shared gate-level datapath.
//  Throughput one op per cycle when the response side is not stalled.
// PARAMETERS
//  N        4   number of requesters (2..8)
//  IDW      2   requester id width, must equal clog2(N)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  req_valid  in   N      per-requester request valid
//  req_ready  out  N      per-requester accept, at most one bit set
//  req_op     in   2*N    op of requester i at [2i+1:2i]
//  req_a      in   16*N   operand a of requester i at [16i+15:16i]
//  req_b      in   16*N   operand b of requester i at [16i+15:16i]
//  rsp_valid  out  1      result valid
//  rsp_ready  in   1      consumer accepts result
//  rsp_data   out  16     result
//  rsp_id     out  IDW    index of requester that issued the op
// BEHAVIOUR
//  - Reset (async): state=IDLE, ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0.
//    req_ready=0 while reset is high.
//  - Ops: 00 a|b, 01 a&b, 10 a^b, 11 ~a (b ignored). Pure 16-bit, no carry.
//  - States: IDLE (no result held), HOLD (result held, rsp_valid=1).
//  - can_issue = (state==IDLE) | (state==HOLD & rsp_ready).
//  - Grant: when can_issue, search req_valid from index ptr upward, wrapping
//    mod N; first set bit i wins; req_ready[i]=1 combinationally, others 0.
//    No grant when no req_valid set; req_ready is all-zero then.
//  - Accept (req_valid[i] & req_ready[i]) at edge k: rsp_data<=op(a_i,b_i),
//    rsp_id<=i, rsp_valid<=1, state<=HOLD, ptr<=(i+1) mod N. Latency 1 cycle.
//  - HOLD & rsp_ready & no accept: rsp_valid<=0, state<=IDLE; rsp_data,
//    rsp_id keep last values.
//  - HOLD & rsp_ready & accept same cycle: back-to-back, rsp_valid stays 1,
//    new data/id load; no bubble.
//  - HOLD & !rsp_ready: rsp_valid, rsp_data, rsp_id stable; req_ready all 0.
//  - ptr advances only on accept; a requester holding valid is granted within
//    N accepts (no starvation).
//  - Requesters must hold op/a/b stable while valid and not ready; withdrawing
//    valid before ready is allowed and simply loses the slot.
//  - Reset mid-operation: held result discarded, ptr returns to 0.
// CONFIGURATION
//  LOGIC16_ARB_GRANT_CNT_EN defined: adds output grant_cnt [16*N-1:0]; slice i
//    counts accepts of requester i, reset to 0, wraps 0xFFFF->0x0000.
//  Not defined: port and counters absent; all other behaviour identical.
// TESTING
//  1 Reset held, all valid=1 -> req_ready=0, rsp_valid=0; release -> req0 granted.
//  2 Req1 alone, op=00, a=0x00F0, b=0x0F0F, rsp_ready=1 -> next cycle
//    rsp_valid=1, rsp_data=0x0FFF, rsp_id=1; following cycle rsp_valid=0.
//  3 All 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive
//    cycles, rsp_id sequence matches, rsp_valid never drops.
//  4 Req2 op=11 a=0x1234 accepted, rsp_ready=0 for 3 cycles -> rsp_data=0xEDCB
//    stable, req_ready=0; rsp_ready=1 -> pending req3 granted same cycle.
//  5 Ops 01/10 on a=0xFF00,b=0x0FF0 -> 0x0F00 and 0xF0F0.
//  6 Assert reset while in HOLD -> rsp_valid=0 immediately, ptr=0;
//    with GRANT_CNT_EN, counters read 0 and increment per accept.

Source files
------------

// File: rtl/logic16_arbiter.sv
// logic16_arbiter
//   Shares one 16-bit bitwise logic unit (OR/AND/XOR/NOT) between N requesters.
//   Round-robin grant starting at a rotating pointer, valid/ready handshake on
//   both sides, and a registered result tagged with the issuing requester's id.
//   One op per cycle when the response side is not stalled.
//
// Parameters
//   N    number of requesters (2..8)
//   IDW  requester id width, equal to clog2(N)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   req_valid  in   [N]      per-requester request valid
//   req_ready  out  [N]      per-requester accept (one-hot or zero, combinational)
//   req_op     in   [2N]     op of requester i at [2i+1:2i]  (00 or, 01 and, 10 xor, 11 not a)
//   req_a      in   [16N]    operand a of requester i at [16i+15:16i]
//   req_b      in   [16N]    operand b of requester i at [16i+15:16i]
//   rsp_valid  out           result valid
//   rsp_ready  in            consumer accepts result
//   rsp_data   out  [16]     result
//   rsp_id     out  [IDW]    index of requester that issued the op
//   grant_cnt  out  [16N]    per-requester accept counters (only with LOGIC16_ARB_GRANT_CNT_EN)
//
// Optional feature macro: LOGIC16_ARB_GRANT_CNT_EN

module logic16_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [2*N-1:0]    req_op,
    input  logic [16*N-1:0]   req_a,
    input  logic [16*N-1:0]   req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_data,
`ifdef LOGIC16_ARB_GRANT_CNT_EN
    output logic [16*N-1:0]   grant_cnt,
`endif
    output logic [IDW-1:0]    rsp_id
);

    localparam int IW1 = IDW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_r, state_next_s;
    logic [IDW-1:0]  ptr_r, ptr_next_s;
    logic            rsp_valid_r, rsp_valid_next_s;
    logic [15:0]     rsp_data_r, rsp_data_next_s;
    logic [IDW-1:0]  rsp_id_r, rsp_id_next_s;

    logic            can_issue_s;
    logic            grant_found_s;
    logic [IDW-1:0]  grant_id_s;
    logic [IW1-1:0]  idx_s;
    logic [N-1:0]    ready_s;
    logic            accept_s;
    logic [15:0]     result_s;

    function automatic logic [15:0] logic16_op(input logic [1:0]  op,
                                               input logic [15:0] a,
                                               input logic [15:0] b);
        logic [15:0] r;
        case (op)
            2'b00:   r = a | b;
            2'b01:   r = a & b;
            2'b10:   r = a ^ b;
            2'b11:   r = ~a;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // A new op may enter when nothing is held or the held result leaves this cycle.
    always_comb begin
        can_issue_s = (state_r == IDLE) | ((state_r == HOLD) & rsp_ready);
    end

    // Round-robin search: first valid requester at or after ptr, wrapping mod N.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = {IDW{1'b0}};
        idx_s         = {IW1{1'b0}};
        for (int k = 0; k < N; k++) begin
            idx_s = {1'b0, ptr_r} + IW1'(k);
            if (idx_s >= IW1'(N)) begin
                idx_s = idx_s - IW1'(N);
            end else begin
                idx_s = idx_s;
            end
            if (!grant_found_s && req_valid[idx_s[IDW-1:0]]) begin
                grant_found_s = 1'b1;
                grant_id_s    = idx_s[IDW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot ready toward the winner; forced low while reset is asserted.
    always_comb begin
        ready_s = {N{1'b0}};
        if (grant_found_s && can_issue_s && !reset) begin
            ready_s[grant_id_s] = 1'b1;
        end else begin
            ready_s = {N{1'b0}};
        end
    end

    assign req_ready = ready_s;

    // The winner's valid is known high, so a grant while issuable is an accept.
    always_comb begin
        accept_s = grant_found_s & can_issue_s;
        result_s = logic16_op(req_op[2*grant_id_s +: 2],
                              req_a[16*grant_id_s +: 16],
                              req_b[16*grant_id_s +: 16]);
    end

    // Next-state and next-output logic for the response holding register.
    always_comb begin
        state_next_s     = state_r;
        ptr_next_s       = ptr_r;
        rsp_valid_next_s = rsp_valid_r;
        rsp_data_next_s  = rsp_data_r;
        rsp_id_next_s    = rsp_id_r;
        if (accept_s) begin
            state_next_s     = HOLD;
            rsp_valid_next_s = 1'b1;
            rsp_data_next_s  = result_s;
            rsp_id_next_s    = grant_id_s;
            if (grant_id_s == IDW'(N - 1)) begin
                ptr_next_s = {IDW{1'b0}};
            end else begin
                ptr_next_s = grant_id_s + {{(IDW-1){1'b0}}, 1'b1};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_next_s = IDLE;
                end
                HOLD: begin
                    // Drained with nothing new: data and id keep their last values.
                    if (rsp_ready) begin
                        state_next_s     = IDLE;
                        rsp_valid_next_s = 1'b0;
                    end else begin
                        state_next_s = HOLD;
                    end
                end
                default: begin
                    state_next_s     = IDLE;
                    rsp_valid_next_s = 1'b0;
                end
            endcase
        end
    end

    // State, pointer and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            ptr_r       <= {IDW{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 16'h0000;
            rsp_id_r    <= {IDW{1'b0}};
        end else begin
            state_r     <= state_next_s;
            ptr_r       <= ptr_next_s;
            rsp_valid_r <= rsp_valid_next_s;
            rsp_data_r  <= rsp_data_next_s;
            rsp_id_r    <= rsp_id_next_s;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;

`ifdef LOGIC16_ARB_GRANT_CNT_EN
    logic [15:0] cnt_r [N];

    // Per-requester accept counters, wrapping at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (accept_s && (grant_id_s == IDW'(i))) begin
                    cnt_r[i] <= cnt_r[i] + 16'h0001;
                end
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_cnt_out
        assign grant_cnt[16*g +: 16] = cnt_r[g];
    end
`endif

endmodule

// File: tb/tb_logic16_arbiter.sv
// tb_logic16_arbiter
//   Directed self-checking bench for logic16_arbiter (N=4). Each task drives one
//   scenario and checks outputs #1 after the rising edge / after input changes.
//   With LOGIC16_ARB_GRANT_CNT_EN defined the grant counters are also checked.

module tb_logic16_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [2*N-1:0]    req_op;
    logic [16*N-1:0]   req_a;
    logic [16*N-1:0]   req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_data;
    logic [IDW-1:0]    rsp_id;
`ifdef LOGIC16_ARB_GRANT_CNT_EN
    logic [16*N-1:0]   grant_cnt;
`endif

    int errors;
    int checks;

    logic16_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
`ifdef LOGIC16_ARB_GRANT_CNT_EN
        .grant_cnt (grant_cnt),
`endif
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_op    = 8'h00;
        req_a     = {16'h0004, 16'h0003, 16'h0002, 16'h00A0};
        req_b     = {16'h0000, 16'h0000, 16'h0000, 16'h000B};
        tick();
        tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected %b", req_ready, 4'b0000); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected %b", rsp_valid, 1'b0); end
        checks++; if (rsp_data !== 16'h0000 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_data: got %h/%0d expected 0000/0", rsp_data, rsp_id); end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL release_grant: got %b expected %b", req_ready, 4'b0001); end
        tick();
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'h00AB) begin errors++; $display("FAIL release_rsp: got %b/%0d/%h expected 1/0/00ab", rsp_valid, rsp_id, rsp_data); end
        tick();
    endtask

    task automatic test_single_or();
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        req_op    = 8'b00_00_00_00;
        req_a[31:16] = 16'h00F0;
        req_b[31:16] = 16'h0F0F;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b expected %b", req_ready, 4'b0010); end
        tick();
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0FFF || rsp_id !== 2'd1) begin errors++; $display("FAIL single_rsp: got %b/%h/%0d expected 1/0fff/1", rsp_valid, rsp_data, rsp_id); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected %b", rsp_valid, 1'b0); end
        checks++; if (rsp_data !== 16'h0FFF) begin errors++; $display("FAIL single_keep: got %h expected %h", rsp_data, 16'h0FFF); end
    endtask

    task automatic test_round_robin();
        logic [15:0] pats [4];
        int          e;
        pats[0] = 16'h1111; pats[1] = 16'h2222; pats[2] = 16'h3333; pats[3] = 16'h4444;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        req_op = 8'h00;
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = pats[i];
            req_b[16*i +: 16] = 16'h0000;
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            e = c % 4;
            checks++; if (req_ready !== (4'b0001 << e)) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, req_ready, 4'b0001 << e); end
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(e) || rsp_data !== pats[e]) begin errors++; $display("FAIL rr_rsp[%0d]: got %b/%0d/%h expected 1/%0d/%h", c, rsp_valid, rsp_id, rsp_data, e, pats[e]); end
        end
        req_valid = 4'b0000;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b expected %b", rsp_valid, 1'b0); end
    endtask

    task automatic test_stall();
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        req_op[5:4]  = 2'b11;
        req_a[47:32] = 16'h1234;
        req_b[47:32] = 16'hFFFF;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL stall_grant: got %b expected %b", req_ready, 4'b0100); end
        tick();
        req_valid = 4'b1000;
        req_op[7:6]  = 2'b00;
        req_a[63:48] = 16'h0003;
        req_b[63:48] = 16'h0030;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hEDCB || rsp_id !== 2'd2) begin errors++; $display("FAIL stall_hold[%0d]: got %b/%h/%0d expected 1/edcb/2", c, rsp_valid, rsp_data, rsp_id); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected %b", c, req_ready, 4'b0000); end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL stall_release: got %b expected %b", req_ready, 4'b1000); end
        tick();
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0033 || rsp_id !== 2'd3) begin errors++; $display("FAIL stall_next: got %b/%h/%0d expected 1/0033/3", rsp_valid, rsp_data, rsp_id); end
        tick();
    endtask

    task automatic test_back_to_back();
        req_valid    = 4'b0001;
        rsp_ready    = 1'b1;
        req_op[1:0]  = 2'b01;
        req_a[15:0]  = 16'hFF00;
        req_b[15:0]  = 16'h0FF0;
        tick();
        req_op[1:0] = 2'b10;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0F00 || rsp_id !== 2'd0) begin errors++; $display("FAIL and_rsp: got %b/%h/%0d expected 1/0f00/0", rsp_valid, rsp_data, rsp_id); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_ready: got %b expected %b", req_ready, 4'b0001); end
        tick();
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hF0F0) begin errors++; $display("FAIL xor_rsp: got %b/%h expected 1/f0f0", rsp_valid, rsp_data); end
        tick();
    endtask

    task automatic test_reset_in_hold();
        req_valid    = 4'b0010;
        rsp_ready    = 1'b0;
        req_op[3:2]  = 2'b00;
        req_a[31:16] = 16'h5555;
        req_b[31:16] = 16'h0000;
        tick();
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h5555) begin errors++; $display("FAIL hold_pre: got %b/%h expected 1/5555", rsp_valid, rsp_data); end
        reset = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || rsp_id !== 2'd0) begin errors++; $display("FAIL hold_reset: got %b/%h/%0d expected 0/0000/0", rsp_valid, rsp_data, rsp_id); end
`ifdef LOGIC16_ARB_GRANT_CNT_EN
        checks++; if (grant_cnt !== 64'h0) begin errors++; $display("FAIL cnt_reset: got %h expected 0", grant_cnt); end
`endif
        reset     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ptr_reset: got %b expected %b", req_ready, 4'b0001); end
        tick();
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL post_reset_rsp: got %b/%0d expected 1/0", rsp_valid, rsp_id); end
`ifdef LOGIC16_ARB_GRANT_CNT_EN
        checks++; if (grant_cnt !== {16'h0, 16'h0, 16'h0, 16'h1}) begin errors++; $display("FAIL cnt_incr: got %h expected 0000000000000001", grant_cnt); end
`endif
        tick();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        req_op    = 8'h00;
        req_a     = 64'h0;
        req_b     = 64'h0;
        test_reset();
        test_single_or();
        test_round_robin();
        test_stall();
        test_back_to_back();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
